// File: rtl/ir_rx_pkg.sv
// Shared types and constants for the IR car-control packet receiver.
// Field indices follow the on-air burst order; command bits map to drive directions.
package ir_rx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW
  } state_t;

  localparam logic [2:0] F_START = 3'd0;
  localparam logic [2:0] F_SEL   = 3'd1;
  localparam logic [2:0] F_BIT0  = 3'd2;
  localparam logic [2:0] F_BIT1  = 3'd3;
  localparam logic [2:0] F_BIT2  = 3'd4;
  localparam logic [2:0] F_BIT3  = 3'd5;

  localparam int CMD_RIGHT = 0;
  localparam int CMD_LEFT  = 1;
  localparam int CMD_BACK  = 2;
  localparam int CMD_FWD   = 3;

  localparam int DEF_CNT_W       = 20;
  localparam int DEF_ZERO_MIN    = 30000;
  localparam int DEF_ONE_MIN     = 95000;
  localparam int DEF_SEL_MIN     = 110000;
  localparam int DEF_SEL_MAX     = 150000;
  localparam int DEF_START_MIN   = 400000;
  localparam int DEF_GAP_TIMEOUT = 200000;

endpackage

// File: rtl/ir_input_sync.sv
// Brings the asynchronous IR envelope into the CLK domain and derives
// single-cycle rise/fall strobes from the synchronised level.
module ir_input_sync (
  input  logic CLK,
  input  logic RESET_N,
  input  logic i_ir,
  output logic o_ir_s,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_ir_s;
  logic r_ir_d;

  // NOTE: non-blocking assignments make each flop capture its predecessor's
  // pre-edge value; blocking ones would collapse the chain into one stage.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_meta <= 1'b0;
      r_ir_s <= 1'b0;
      r_ir_d <= 1'b0;
    end else begin
      r_meta <= i_ir;
      r_ir_s <= r_meta;
      r_ir_d <= r_ir_s;
    end
  end

  assign o_ir_s = r_ir_s;
  assign o_rise = r_ir_s & ~r_ir_d;
  assign o_fall = ~r_ir_s & r_ir_d;

endmodule

// File: rtl/ir_packet_receiver.sv
// IR packet decoder: measures burst/gap widths in CLK cycles, walks the
// start/select/data fields and publishes a registered 4-bit drive command.
module ir_packet_receiver
  import ir_rx_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int ZERO_MIN    = DEF_ZERO_MIN,
  parameter int ONE_MIN     = DEF_ONE_MIN,
  parameter int SEL_MIN     = DEF_SEL_MIN,
  parameter int SEL_MAX     = DEF_SEL_MAX,
  parameter int START_MIN   = DEF_START_MIN,
  parameter int GAP_TIMEOUT = DEF_GAP_TIMEOUT
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       ENABLE,
  input  logic       IR_IN,
  output logic [3:0] COMMAND,
  output logic       CMD_VALID,
  output logic       PKT_ERR,
  output logic       BUSY
);

  localparam logic [CNT_W-1:0] L_ZERO_MIN    = CNT_W'(ZERO_MIN);
  localparam logic [CNT_W-1:0] L_ONE_MIN     = CNT_W'(ONE_MIN);
  localparam logic [CNT_W-1:0] L_SEL_MIN     = CNT_W'(SEL_MIN);
  localparam logic [CNT_W-1:0] L_SEL_MAX     = CNT_W'(SEL_MAX);
  localparam logic [CNT_W-1:0] L_START_MIN   = CNT_W'(START_MIN);
  localparam logic [CNT_W-1:0] L_GAP_TIMEOUT = CNT_W'(GAP_TIMEOUT);

  logic             w_ir_s;
  logic             w_rise;
  logic             w_fall;
  logic [CNT_W-1:0] w_cnt_next;
  state_t           w_state_next;
  logic [2:0]       w_field_next;
  logic [3:0]       w_bits_next;
  logic [1:0]       w_bit_idx;
  logic             w_done;
  logic             w_err;
  logic             w_timeout;

  state_t           r_state;
  logic [2:0]       r_field;
  logic [3:0]       r_bits;
  logic [CNT_W-1:0] r_cnt;
  logic             r_done_pend;
  logic             r_err_pend;
  logic [3:0]       r_cmd_pend;
  logic [3:0]       r_command;
  logic             r_cmd_valid;
  logic             r_pkt_err;

  ir_input_sync u_sync (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .i_ir    (IR_IN),
    .o_ir_s  (w_ir_s),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  // At a fall, r_cnt still holds the number of cycles ir_s was high.
  assign w_cnt_next = (w_rise || w_fall) ? CNT_W'(1) :
                      (&r_cnt)           ? r_cnt     : r_cnt + CNT_W'(1);
  assign w_bit_idx  = 2'(r_field - F_BIT0);

  // NOTE: every always_comb output gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_field_next = r_field;
    w_bits_next  = r_bits;
    w_done       = 1'b0;
    w_err        = 1'b0;
    w_timeout    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_rise) begin
          w_state_next = HIGH;
          w_field_next = F_START;
        end
      end
      HIGH: begin
        if (w_fall) begin
          if (r_field == F_START) begin
            w_state_next = (r_cnt >= L_START_MIN) ? LOW : IDLE;
            w_field_next = F_SEL;
          end else if (r_field == F_SEL) begin
            if (r_cnt >= L_SEL_MIN && r_cnt <= L_SEL_MAX) begin
              w_state_next = LOW;
              w_field_next = F_BIT0;
            end else begin
              w_state_next = IDLE;
              w_err        = 1'b1;
            end
          end else if (r_cnt < L_ZERO_MIN) begin
            w_state_next = IDLE;
            w_err        = 1'b1;
          end else if (r_cnt >= L_START_MIN) begin
            // A start-length burst inside a packet restarts the packet.
            w_state_next = LOW;
            w_field_next = F_SEL;
          end else begin
            w_bits_next[w_bit_idx] = (r_cnt >= L_ONE_MIN);
            if (r_field == F_BIT3) begin
              w_state_next = IDLE;
              w_done       = 1'b1;
            end else begin
              w_state_next = LOW;
              w_field_next = r_field + 3'd1;
            end
          end
        end
      end
      LOW: begin
        if (w_rise) begin
          w_state_next = HIGH;
        end else if (w_cnt_next == L_GAP_TIMEOUT) begin
          w_state_next = IDLE;
          w_timeout    = 1'b1;
        end
      end
      default: w_state_next = IDLE;
    endcase
    if (!ENABLE) begin
      w_state_next = IDLE;
      w_done       = 1'b0;
      w_err        = 1'b0;
      w_timeout    = 1'b0;
    end
  end

  // Classification results wait one cycle in *_pend before reaching the
  // outputs; a gap timeout is reported in the cycle the counter reaches it.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state     <= IDLE;
      r_field     <= F_START;
      r_bits      <= 4'd0;
      r_cnt       <= '0;
      r_done_pend <= 1'b0;
      r_err_pend  <= 1'b0;
      r_cmd_pend  <= 4'd0;
      r_command   <= 4'd0;
      r_cmd_valid <= 1'b0;
      r_pkt_err   <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_field     <= w_field_next;
      r_bits      <= w_bits_next;
      r_cnt       <= w_cnt_next;
      r_done_pend <= w_done;
      r_err_pend  <= w_err;
      if (w_done) begin
        r_cmd_pend <= w_bits_next;
      end
      r_cmd_valid <= r_done_pend & ENABLE;
      r_pkt_err   <= (r_err_pend & ENABLE) | w_timeout;
      if (r_done_pend && ENABLE) begin
        r_command <= r_cmd_pend;
      end
    end
  end

  assign COMMAND   = r_command;
  assign CMD_VALID = r_cmd_valid;
  assign PKT_ERR   = r_pkt_err;
  assign BUSY      = (r_state != IDLE);

endmodule

// File: doc/ir_packet_receiver.md
Name: ir_packet_receiver

Overview:
- Receiving end of the IR car-control link. Decodes the demodulated IR envelope (high = carrier present) into a 4-bit drive command.
- Packet: start burst, car-select burst, then four data bursts in order RIGHT, LEFT, BACKWARD, FORWARD. A long data burst means 1, a short one means 0. Each burst is separated by a carrier-off gap.
- Burst widths are measured in CLK cycles, classified against parameter thresholds, and reported as a registered command with a one-cycle valid strobe.

Parameters:
- CNT_W, 20, width of the burst/gap counter; the counter saturates at 2^CNT_W-1.
- ZERO_MIN, 30000, minimum high length (CLK cycles) of a valid data burst.
- ONE_MIN, 95000, a data burst at or above this length is a 1.
- SEL_MIN, 110000, lower bound (inclusive) of the car-select burst.
- SEL_MAX, 150000, upper bound (inclusive) of the car-select burst.
- START_MIN, 400000, minimum high length of a start burst.
- GAP_TIMEOUT, 200000, maximum low length between bursts inside a packet.

Ports:
- CLK  in  1  system clock.
- RESET_N  in  1  asynchronous, active-low reset.
- ENABLE  in  1  decoder enable. When low, the FSM is held in IDLE, CMD_VALID and PKT_ERR are held 0, and COMMAND holds its value.
- IR_IN  in  1  demodulated IR envelope; asynchronous to CLK.
- COMMAND  out  4  last good command: [0]=RIGHT, [1]=LEFT, [2]=BACKWARD, [3]=FORWARD.
- CMD_VALID  out  1  one-cycle pulse when COMMAND updates.
- PKT_ERR  out  1  one-cycle pulse when a packet is aborted.
- BUSY  out  1  high whenever state is not IDLE.

Behaviour:
- Reset values: COMMAND=0, CMD_VALID=0, PKT_ERR=0, BUSY=0, state=IDLE, field=0, counter=0, sync flops=0.
- Input path:
  - IR_IN passes through a 2-flop synchroniser to give ir_s.
  - ir_d is ir_s delayed one cycle.
  - rise = ir_s & ~ir_d; fall = ~ir_s & ir_d.
- Counter: cleared to 1 on rise (entering HIGH) and on fall (entering LOW). Otherwise it increments each cycle, saturating. The value seen at fall equals the number of cycles ir_s was high.
- Field index: 0=start, 1=select, 2..5=data bits.
- FSM states:
  - IDLE: on rise, go to HIGH with field=0.
  - HIGH: on fall, classify the measured length L:
    - field 0: if L>=START_MIN, go to LOW with field=1. Otherwise return to IDLE silently (noise, no PKT_ERR).
    - field 1: if SEL_MIN<=L<=SEL_MAX, go to LOW with field=2. Otherwise PKT_ERR, go to IDLE.
    - fields 2..5:
      - L<ZERO_MIN: PKT_ERR, go to IDLE.
      - L>=START_MIN: resync. Treat as a new start, go to LOW with field=1, no PKT_ERR.
      - otherwise: store bit (1 if L>=ONE_MIN) into shift position field-2.
      - After field 5: COMMAND takes the 4 collected bits, CMD_VALID pulses, go to IDLE.
      - Before field 5: go to LOW with field+1.
  - LOW:
    - On rise, go to HIGH.
    - If the counter reaches GAP_TIMEOUT while low: PKT_ERR, go to IDLE.
- Latency: CMD_VALID and PKT_ERR (classification) assert on the 3rd CLK edge after the edge that first samples the terminating IR_IN fall. Both are registered and high for exactly one cycle.
- Simultaneous events: timeout and rise in the same cycle resolve as rise (burst accepted). ENABLE falling mid-packet is a silent abort: no PKT_ERR, COMMAND unchanged.
- RESET_N asserted mid-operation immediately returns all state and outputs to their reset values. Packet bits collected before reset are discarded.
- COMMAND changes only with CMD_VALID. It is never partially updated.

Decomposition:
- Package ir_rx_pkg:
  - state enum {IDLE, HIGH, LOW};
  - field index constants (F_START, F_SEL, F_BIT0..F_BIT3);
  - command bit index constants (CMD_RIGHT, CMD_LEFT, CMD_BACK, CMD_FWD);
  - default timing constants.
- Sub-module ir_input_sync: 2-flop synchroniser plus ir_d register. Outputs ir_s, rise and fall.

Test Plan (override parameters: ZERO_MIN=4, ONE_MIN=10, SEL_MIN=12, SEL_MAX=16, START_MIN=30, GAP_TIMEOUT=20, CNT_W=8):
- Valid packet: start 40, gap 8, select 14, then bits 12/5/5/12 with gaps 8 -> CMD_VALID single pulse, COMMAND=4'b1001, PKT_ERR never high, BUSY low afterwards.
- Select 20 (above SEL_MAX) -> PKT_ERR one pulse 3 edges after the select burst ends, no CMD_VALID, COMMAND unchanged at 4'b1001.
- Gap 25 after the 2nd data bit -> PKT_ERR on the cycle the counter hits 20, state IDLE, COMMAND unchanged.
- Noise handling:
  - 3-cycle glitch in a data slot -> PKT_ERR.
  - 10-cycle burst from IDLE -> no PKT_ERR, BUSY falls back to 0.
- Resync: start, select, one bit, then a 35-cycle burst, then select 14 and bits 5/5/12/12 -> single CMD_VALID, COMMAND=4'b1100, no PKT_ERR.
- Reset and enable:
  - RESET_N low after the 3rd data bit -> all outputs 0 immediately; a following full packet decodes normally.
  - ENABLE low mid-packet -> no pulses, COMMAND held.
